// File: rtl/sramlike_arbiter.sv
// Two-master arbiter for one SRAM-like slave port; an owner FIFO routes in-order responses back.
// Optional macro ARB_RR_EN selects round-robin idle arbitration instead of fixed m1 > m0 priority.
module sramlike_arbiter #(
    parameter int OT_DEPTH = 4,
    parameter int PTR_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  m0_cen,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_rrdy,
    output logic [31:0] m0_rdata,
    input  logic [3:0]  m1_cen,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_rrdy,
    output logic [31:0] m1_rdata,
    output logic [3:0]  s_cen,
    output logic        s_wr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    input  logic        s_rrdy,
    input  logic [31:0] s_rdata,
    output logic        err_spur
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(OT_DEPTH);

    logic                lock_q, lock_d;
    logic                owner_q, owner_d;
    logic [OT_DEPTH-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                err_spur_q, err_spur_d;
`ifdef ARB_RR_EN
    logic                rr_q, rr_d;
`endif

    logic sel;
    logic full;
    logic push;
    logic pop;
    logic head;

    always_comb begin
        full = (count_q == FULL_CNT);
        // Locked owner keeps the bus; otherwise pick among requesters (sel=1 means m1)
        if (lock_q) begin
            sel = owner_q;
        end else if ((m0_cen != 4'd0) && (m1_cen != 4'd0)) begin
`ifdef ARB_RR_EN
            sel = rr_q;
`else
            sel = 1'b1;
`endif
        end else begin
            sel = (m1_cen != 4'd0);
        end

        s_wr    = sel ? m1_wr    : m0_wr;
        s_addr  = sel ? m1_addr  : m0_addr;
        s_wdata = sel ? m1_wdata : m0_wdata;
        s_cen   = (full || reset) ? 4'd0 : (sel ? m1_cen : m0_cen);

        push   = (s_cen != 4'd0) && s_ack;
        m0_ack = push && !sel;
        m1_ack = push && sel;

        pop      = s_rrdy && (count_q != '0);
        head     = fifo_q[rd_ptr_q];
        m0_rrdy  = pop && !head;
        m1_rrdy  = pop && head;
        m0_rdata = s_rdata;
        m1_rdata = s_rdata;
        err_spur = err_spur_q;
    end

    always_comb begin
        lock_d     = lock_q;
        owner_d    = owner_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        err_spur_d = err_spur_q | (s_rrdy && (count_q == '0));
`ifdef ARB_RR_EN
        rr_d       = push ? ~rr_q : rr_q;
`endif

        if (push) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        // While full the lock state is frozen; an owner dropping cen releases the lock
        if (!full) begin
            if (push) begin
                lock_d = 1'b0;
            end else if (s_cen != 4'd0) begin
                lock_d  = 1'b1;
                owner_d = sel;
            end else begin
                lock_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= 1'b0;
            owner_q    <= 1'b0;
            fifo_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            err_spur_q <= 1'b0;
`ifdef ARB_RR_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            lock_q     <= lock_d;
            owner_q    <= owner_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            err_spur_q <= err_spur_d;
`ifdef ARB_RR_EN
            rr_q       <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Self-checking bench for sramlike_arbiter: vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_sramlike_arbiter;
    localparam int OT_DEPTH = 4;
    localparam logic [31:0] A0 = 32'h1FC0_0000;
    localparam logic [31:0] A1 = 32'h8000_1000;
`ifdef ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  m0_cen, m1_cen, s_cen;
    logic        m0_wr, m1_wr, s_wr;
    logic [31:0] m0_addr, m1_addr, s_addr;
    logic [31:0] m0_wdata, m1_wdata, s_wdata;
    logic        m0_ack, m1_ack, m0_rrdy, m1_rrdy;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_ack, s_rrdy, err_spur;
    logic [31:0] s_rdata;

    int errors = 0;
    int checks = 0;

    sramlike_arbiter #(.OT_DEPTH(OT_DEPTH), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .m0_cen(m0_cen), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rrdy(m0_rrdy), .m0_rdata(m0_rdata),
        .m1_cen(m1_cen), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rrdy(m1_rrdy), .m1_rdata(m1_rdata),
        .s_cen(s_cen), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rrdy(s_rrdy), .s_rdata(s_rdata),
        .err_spur(err_spur)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  m0_cen;
        logic [3:0]  m1_cen;
        logic        s_ack;
        logic        s_rrdy;
        logic [31:0] s_rdata;
        logic [3:0]  e_cen;
        logic        e_sel_m1;
        logic        e_ack0;
        logic        e_ack1;
        logic        e_rrdy0;
        logic        e_rrdy1;
    } vec_t;

    vec_t vecs[18];

    // reference model state: the owner queue holds 0 for m0, 1 for m1
    bit mdl_q[$];
    bit mdl_lock, mdl_owner, mdl_err, mdl_rr;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] c0, input logic [3:0] c1, input logic ack,
                         input logic rr, input logic [31:0] rd);
        m0_cen = c0; m1_cen = c1; s_ack = ack; s_rrdy = rr; s_rdata = rd;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 1'b0, 32'd0);
        m0_addr = A0; m1_addr = A1; m0_wr = 1'b0; m1_wr = 1'b1;
        m0_wdata = 32'hAAAA_0000; m1_wdata = 32'hBBBB_1111;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] c0, input logic [3:0] c1, input logic ack,
                                input logic rr, input logic [31:0] rd, input logic [3:0] ec,
                                input logic es, input logic a0, input logic a1,
                                input logic r0, input logic r1);
        vec_t v;
        v.m0_cen = c0; v.m1_cen = c1; v.s_ack = ack; v.s_rrdy = rr; v.s_rdata = rd;
        v.e_cen = ec; v.e_sel_m1 = es; v.e_ack0 = a0; v.e_ack1 = a1;
        v.e_rrdy0 = r0; v.e_rrdy1 = r1;
        return v;
    endfunction

    // Compares the DUT against the model for the current inputs, then commits the model's clock edge
    task automatic model_check();
        bit full, want0, want1, sel, hs, pop, head, was_empty;
        logic [3:0] e_cen;
        full  = (mdl_q.size() == OT_DEPTH);
        want0 = (m0_cen != 0);
        want1 = (m1_cen != 0);
        if (mdl_lock)          sel = mdl_owner;
        else if (want0 && want1) sel = RR_EN ? mdl_rr : 1'b1;
        else                   sel = want1;
        e_cen = full ? 4'd0 : (sel ? m1_cen : m0_cen);
        hs    = (e_cen != 0) && s_ack;
        was_empty = (mdl_q.size() == 0);
        pop   = s_rrdy && !was_empty;
        head  = pop ? mdl_q[0] : 1'b0;

        check_val("rnd_s_cen", 32'(s_cen), 32'(e_cen));
        if (e_cen != 0) begin
            check_val("rnd_s_addr", s_addr, sel ? m1_addr : m0_addr);
            check_val("rnd_s_wdata", s_wdata, sel ? m1_wdata : m0_wdata);
            check_val("rnd_s_wr", 32'(s_wr), 32'(sel ? m1_wr : m0_wr));
        end
        check_val("rnd_m0_ack", 32'(m0_ack), 32'(hs && !sel));
        check_val("rnd_m1_ack", 32'(m1_ack), 32'(hs && sel));
        check_val("rnd_m0_rrdy", 32'(m0_rrdy), 32'(pop && !head));
        check_val("rnd_m1_rrdy", 32'(m1_rrdy), 32'(pop && head));
        check_val("rnd_m1_rdata", m1_rdata, s_rdata);
        check_val("rnd_err_spur", 32'(err_spur), 32'(mdl_err));

        if (pop) void'(mdl_q.pop_front());
        if (hs) mdl_q.push_back(sel);
        if (s_rrdy && was_empty) mdl_err = 1'b1;
        if (hs) mdl_rr = ~mdl_rr;
        if (!full) begin
            mdl_lock = (e_cen != 0) && !hs;
            if (mdl_lock) mdl_owner = sel;
        end
    endtask

    initial begin
        do_reset();

        // reset state with idle inputs
        check_val("rst_s_cen", 32'(s_cen), 32'd0);
        check_val("rst_err_spur", 32'(err_spur), 32'd0);

        vecs[0]  = mk(4'h0, 4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(4'hF, 4'h0, 1, 0, 32'h0,         4'hF, 0, 1, 0, 0, 0);
        vecs[2]  = mk(4'h0, 4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(4'h0, 4'h0, 0, 1, 32'hDEADBEEF,  4'h0, 0, 0, 0, 1, 0);
        vecs[4]  = mk(4'hF, 4'h3, 1, 0, 32'h0,         4'h3, 1, 0, 1, 0, 0);
        vecs[5]  = mk(4'hF, 4'h0, 1, 0, 32'h0,         4'hF, 0, 1, 0, 0, 0);
        vecs[6]  = mk(4'h0, 4'h0, 0, 1, 32'h11,        4'h0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(4'h0, 4'h0, 0, 1, 32'h22,        4'h0, 0, 0, 0, 1, 0);
        vecs[8]  = mk(4'hF, 4'h0, 0, 0, 32'h0,         4'hF, 0, 0, 0, 0, 0);
        vecs[9]  = mk(4'hF, 4'h3, 0, 0, 32'h0,         4'hF, 0, 0, 0, 0, 0);
        vecs[10] = mk(4'hF, 4'h3, 0, 0, 32'h0,         4'hF, 0, 0, 0, 0, 0);
        vecs[11] = mk(4'hF, 4'h3, 1, 0, 32'h0,         4'hF, 0, 1, 0, 0, 0);
        vecs[12] = mk(4'h0, 4'h3, 1, 0, 32'h0,         4'h3, 1, 0, 1, 0, 0);
        vecs[13] = mk(4'hF, 4'h0, 0, 1, 32'h33,        4'hF, 0, 0, 0, 1, 0);
        vecs[14] = mk(4'h0, 4'h3, 0, 0, 32'h0,         4'h0, 0, 0, 0, 0, 0);
        vecs[15] = mk(4'h0, 4'h3, 1, 0, 32'h0,         4'h3, 1, 0, 1, 0, 0);
        vecs[16] = mk(4'h0, 4'h0, 0, 1, 32'h44,        4'h0, 0, 0, 0, 0, 1);
        vecs[17] = mk(4'h0, 4'h0, 0, 1, 32'h55,        4'h0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].m0_cen, vecs[i].m1_cen, vecs[i].s_ack, vecs[i].s_rrdy, vecs[i].s_rdata);
            @(negedge clk);
            check_val($sformatf("vec%0d_s_cen", i), 32'(s_cen), 32'(vecs[i].e_cen));
            if (vecs[i].e_cen != 0)
                check_val($sformatf("vec%0d_s_addr", i), s_addr, vecs[i].e_sel_m1 ? A1 : A0);
            check_val($sformatf("vec%0d_m0_ack", i), 32'(m0_ack), 32'(vecs[i].e_ack0));
            check_val($sformatf("vec%0d_m1_ack", i), 32'(m1_ack), 32'(vecs[i].e_ack1));
            check_val($sformatf("vec%0d_m0_rrdy", i), 32'(m0_rrdy), 32'(vecs[i].e_rrdy0));
            check_val($sformatf("vec%0d_m1_rrdy", i), 32'(m1_rrdy), 32'(vecs[i].e_rrdy1));
            check_val($sformatf("vec%0d_m0_rdata", i), m0_rdata, vecs[i].s_rdata);
            check_val($sformatf("vec%0d_m1_rdata", i), m1_rdata, vecs[i].s_rdata);
            advance();
        end
        check_val("table_err_spur", 32'(err_spur), 32'd0);

        // fill the owner FIFO, then confirm the fifth request stalls until a response drains one
        for (int i = 0; i < OT_DEPTH; i++) begin
            drive(4'hF, 4'h0, 1, 0, 32'h0);
            @(negedge clk);
            check_val($sformatf("fill%0d_m0_ack", i), 32'(m0_ack), 32'd1);
            advance();
        end
        drive(4'hF, 4'h3, 1, 0, 32'h0);
        @(negedge clk);
        check_val("full_s_cen", 32'(s_cen), 32'd0);
        check_val("full_acks", 32'({m0_ack, m1_ack}), 32'd0);
        advance();
        drive(4'hF, 4'h0, 1, 1, 32'h66);
        @(negedge clk);
        check_val("full_pop_s_cen", 32'(s_cen), 32'd0);
        check_val("full_pop_m0_ack", 32'(m0_ack), 32'd0);
        check_val("full_pop_m0_rrdy", 32'(m0_rrdy), 32'd1);
        advance();
        drive(4'hF, 4'h0, 1, 0, 32'h0);
        @(negedge clk);
        check_val("unblock_s_cen", 32'(s_cen), 32'hF);
        check_val("unblock_m0_ack", 32'(m0_ack), 32'd1);
        advance();
        for (int i = 0; i < OT_DEPTH; i++) begin
            drive(4'h0, 4'h0, 0, 1, 32'h70 + 32'(i));
            @(negedge clk);
            check_val($sformatf("drain%0d_m0_rrdy", i), 32'(m0_rrdy), 32'd1);
            advance();
        end

        // spurious response with the FIFO empty sets the sticky flag
        drive(4'h0, 4'h0, 0, 1, 32'h99);
        @(negedge clk);
        check_val("spur_rrdy", 32'({m0_rrdy, m1_rrdy}), 32'd0);
        advance();
        drive(4'h0, 4'h0, 0, 0, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check_val("spur_sticky", 32'(err_spur), 32'd1);
            advance();
        end
        reset = 1'b1;
        #1;
        check_val("spur_cleared", 32'(err_spur), 32'd0);
        advance();
        reset = 1'b0;

        // reset with an accepted transaction outstanding discards its ownership
        drive(4'hF, 4'h0, 1, 0, 32'h0);
        @(negedge clk);
        check_val("midrst_accept", 32'(m0_ack), 32'd1);
        advance();
        reset = 1'b1;
        #1;
        check_val("midrst_s_cen", 32'(s_cen), 32'd0);
        check_val("midrst_m0_ack", 32'(m0_ack), 32'd0);
        advance();
        reset = 1'b0;
        drive(4'h0, 4'h0, 0, 1, 32'h77);
        @(negedge clk);
        check_val("midrst_no_rrdy", 32'({m0_rrdy, m1_rrdy}), 32'd0);
        advance();
        drive(4'h0, 4'h0, 0, 0, 32'h0);
        @(negedge clk);
        check_val("midrst_err_spur", 32'(err_spur), 32'd1);
        advance();

`ifdef ARB_RR_EN
        do_reset();
        for (int i = 0; i < OT_DEPTH; i++) begin
            drive(4'hF, 4'h3, 1, 0, 32'h0);
            @(negedge clk);
            check_val($sformatf("rr%0d_m1_ack", i), 32'(m1_ack), 32'(i % 2));
            check_val($sformatf("rr%0d_m0_ack", i), 32'(m0_ack), 32'(1 - (i % 2)));
            advance();
        end
        reset = 1'b1;
        #1;
        check_val("rr_rst_s_cen", 32'(s_cen), 32'd0);
        advance();
        reset = 1'b0;
`endif

        // randomized traffic against the queue model
        do_reset();
        mdl_q.delete();
        mdl_lock = 0; mdl_owner = 0; mdl_err = 0; mdl_rr = 0;
        for (int i = 0; i < 600; i++) begin
            m0_cen   = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            m1_cen   = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            m0_wr    = 1'($urandom_range(0, 1));
            m1_wr    = 1'($urandom_range(0, 1));
            m0_addr  = $urandom;
            m1_addr  = $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            s_ack    = ($urandom_range(0, 9) < 6);
            s_rrdy   = ($urandom_range(0, 9) < 4);
            s_rdata  = $urandom;
            @(negedge clk);
            model_check();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
